// File: rtl/compare_pkg.sv
// Compare codes and legality helper shared by the branch-compare arbiter and its datapath.
package compare_pkg;
   localparam int CMP_W = 3;

   localparam logic [CMP_W-1:0] CMP_GTZ = 3'd0;
   localparam logic [CMP_W-1:0] CMP_LTZ = 3'd1;
   localparam logic [CMP_W-1:0] CMP_GEZ = 3'd2;
   localparam logic [CMP_W-1:0] CMP_LEZ = 3'd3;
   localparam logic [CMP_W-1:0] CMP_EQ  = 3'd4;
   localparam logic [CMP_W-1:0] CMP_NEQ = 3'd5;

   function automatic logic cmp_legal(input logic [CMP_W-1:0] code);
      return (code <= CMP_NEQ);
   endfunction
endpackage

// File: rtl/compare_core.sv
// Combinational signed branch-condition evaluator; illegal codes yield result=0, illegal=1.
module compare_core
   import compare_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [CMP_W-1:0]  ctrl,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              result,
   output logic              illegal
);
   logic a_neg;
   logic a_zero;

   assign a_neg  = a[DATA_W-1];
   assign a_zero = (a == '0);

   always_comb begin
      result  = 1'b0;
      illegal = !cmp_legal(ctrl);
      case (ctrl)
         CMP_GTZ: result = !a_neg && !a_zero;
         CMP_LTZ: result = a_neg;
         CMP_GEZ: result = !a_neg;
         CMP_LEZ: result = a_neg || a_zero;
         CMP_EQ:  result = (a == b);
         CMP_NEQ: result = (a != b);
         default: result = 1'b0;
      endcase
   end
endmodule

// File: rtl/compare_arbiter.sv
// Round-robin share of one branch-compare datapath; 2-cycle latency from accept to one-hot response.
module compare_arbiter
   import compare_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32
) (
   input  logic                      Clk,
   input  logic                      Rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [CMP_W*NUM_REQ-1:0]  req_ctrl,
   input  logic [DATA_W*NUM_REQ-1:0] req_a,
   input  logic [DATA_W*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]        resp_valid,
   output logic                      resp_result,
   output logic                      resp_err,
   output logic                      busy
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  win;
   logic              found;
   logic              accept;
   logic              s1_valid;
   logic [CMP_W-1:0]  s1_ctrl;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic [IDX_W-1:0]  s1_owner;
   logic              core_result;
   logic              core_illegal;
   logic [NUM_REQ-1:0] owner_onehot;

   // Scan from ptr upward with wrap; first valid requester wins.
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req_valid[IDX_W'(j)]) begin
            found = 1'b1;
            win   = IDX_W'(j);
         end
      end
   end

   // Ready is forced low while reset is held so nothing is accepted before release.
   always_comb begin
      req_ready = '0;
      if (found && Rst_n) req_ready[win] = 1'b1;
   end

   assign accept = |req_ready;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ptr      <= '0;
         s1_valid <= 1'b0;
         s1_ctrl  <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_owner <= '0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            ptr      <= (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + IDX_W'(1);
            s1_ctrl  <= req_ctrl[CMP_W*win +: CMP_W];
            s1_a     <= req_a[DATA_W*win +: DATA_W];
            s1_b     <= req_b[DATA_W*win +: DATA_W];
            s1_owner <= win;
         end
      end
   end

   compare_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .ctrl    (s1_ctrl),
      .a       (s1_a),
      .b       (s1_b),
      .result  (core_result),
      .illegal (core_illegal)
   );

   always_comb begin
      owner_onehot = '0;
      owner_onehot[s1_owner] = 1'b1;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         resp_valid  <= '0;
         resp_result <= 1'b0;
         resp_err    <= 1'b0;
      end else begin
         resp_valid  <= s1_valid ? owner_onehot : '0;
         resp_result <= s1_valid && core_result;
         resp_err    <= s1_valid && core_illegal;
      end
   end

   assign busy = s1_valid | (|resp_valid);
endmodule

// File: tb/tb_compare_arbiter.sv
// Bench for compare_arbiter: constant vector table, directed multi-cycle sequences, random traffic vs a queue model.
module tb_compare_arbiter;
   import compare_pkg::*;

   localparam int N = 3;
   localparam int W = 32;

   logic           Clk = 1'b0;
   logic           Rst_n = 1'b0;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [3*N-1:0] req_ctrl;
   logic [W*N-1:0] req_a;
   logic [W*N-1:0] req_b;
   logic [N-1:0]   resp_valid;
   logic           resp_result;
   logic           resp_err;
   logic           busy;

   compare_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid),
      .resp_result(resp_result), .resp_err(resp_err), .busy(busy)
   );

   always #5 Clk = ~Clk;

   typedef struct {int due; int owner; logic res; logic err;} exp_t;
   typedef struct {logic [2:0] ctrl; logic [W-1:0] a; logic [W-1:0] b; logic res; logic err;} vec_t;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int ptr_m = 0;
   int last_win = -1;
   exp_t q[$];
   logic [N-1:0] seen_ready, seen_rv;
   logic seen_res, seen_err;
   vec_t tbl[14];
   logic [N-1:0] grant_exp[4];
   bit pending[N];

   function automatic logic ref_cmp(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa;
      sa = $signed(a);
      case (c)
         3'd0: return sa > 0;
         3'd1: return sa < 0;
         3'd2: return sa >= 0;
         3'd3: return sa <= 0;
         3'd4: return a == b;
         3'd5: return a != b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [2:0] c,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[i]        = v;
      req_ctrl[3*i +: 3]  = c;
      req_a[W*i +: W]     = a;
      req_b[W*i +: W]     = b;
   endtask

   // One clock cycle: checks at the falling edge, then advances the model and returns at posedge+1.
   task automatic cycle();
      logic [N-1:0] er, ev;
      bit found, bz;
      int w, j;
      exp_t e;
      @(negedge Clk);
      er = '0; found = 0; w = 0;
      for (int k = 0; k < N; k++) begin
         j = (ptr_m + k) % N;
         if (!found && req_valid[j]) begin
            found = 1; w = j;
         end
      end
      if (found) er[w] = 1'b1;
      check("req_ready", req_ready, er);
      bz = 0;
      foreach (q[x]) if (q[x].due == cyc || q[x].due == cyc + 1) bz = 1;
      check("busy", busy, bz);
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         ev = '0; ev[e.owner] = 1'b1;
         check("resp_valid", resp_valid, ev);
         check("resp_result", resp_result, e.res);
         check("resp_err", resp_err, e.err);
      end else begin
         check("resp_valid_idle", resp_valid, '0);
      end
      seen_ready = req_ready; seen_rv = resp_valid; seen_res = resp_result; seen_err = resp_err;
      last_win = found ? w : -1;
      if (found) begin
         q.push_back('{due: cyc + 2, owner: w,
                       res: ref_cmp(req_ctrl[3*w +: 3], req_a[W*w +: W], req_b[W*w +: W]),
                       err: (req_ctrl[3*w +: 3] > 3'd5)});
         ptr_m = (w + 1) % N;
      end
      @(posedge Clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      req_valid = '1;
      Rst_n = 1'b0;
      #1;
      check("rst_ready", req_ready, '0);
      check("rst_resp_valid", resp_valid, '0);
      check("rst_busy", busy, 1'b0);
      req_valid = '0;
      @(posedge Clk);
      cyc++;
      #1;
      Rst_n = 1'b1;
      q.delete();
      ptr_m = 0;
   endtask

   // Issue one request alone and run until its response cycle; seen_* then holds the response.
   task automatic issue(input int i, input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
      set_req(i, 1'b1, c, a, b);
      cycle();
      req_valid[i] = 1'b0;
      cycle();
      cycle();
   endtask

   function automatic logic [W-1:0] rnd_val();
      case ($urandom_range(0, 3))
         0: return '0;
         1: return W'($urandom_range(0, 6)) - W'(3);
         2: return ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [W-1:0] ra;
      tbl[0]  = '{CMP_EQ,  32'd5,          32'd5,          1'b1, 1'b0};
      tbl[1]  = '{CMP_LTZ, 32'hFFFF_FFFF,  32'd9,          1'b1, 1'b0};
      tbl[2]  = '{CMP_GTZ, 32'd0,          32'd1,          1'b0, 1'b0};
      tbl[3]  = '{CMP_LEZ, 32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0};
      tbl[4]  = '{CMP_GTZ, 32'h8000_0000,  32'd0,          1'b0, 1'b0};
      tbl[5]  = '{CMP_GTZ, 32'h7FFF_FFFF,  32'd0,          1'b1, 1'b0};
      tbl[6]  = '{CMP_LTZ, 32'h8000_0000,  32'd0,          1'b1, 1'b0};
      tbl[7]  = '{CMP_GEZ, 32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
      tbl[8]  = '{CMP_LEZ, 32'd1,          32'd0,          1'b0, 1'b0};
      tbl[9]  = '{CMP_EQ,  32'd5,          32'd6,          1'b0, 1'b0};
      tbl[10] = '{CMP_NEQ, 32'd3,          32'd4,          1'b1, 1'b0};
      tbl[11] = '{CMP_EQ,  32'h8000_0000,  32'd0,          1'b0, 1'b0};
      tbl[12] = '{3'd6,    32'd1,          32'd1,          1'b0, 1'b1};
      tbl[13] = '{3'd7,    32'd0,          32'd0,          1'b0, 1'b1};
      grant_exp[0] = 3'b001; grant_exp[1] = 3'b010; grant_exp[2] = 3'b001; grant_exp[3] = 3'b010;

      req_valid = '0; req_ctrl = '0; req_a = '0; req_b = '0;
      repeat (2) @(posedge Clk);
      #1;
      do_reset();

      // Vector table through requester 0, one at a time.
      for (int t = 0; t < 14; t++) begin
         issue(0, tbl[t].ctrl, tbl[t].a, tbl[t].b);
         check($sformatf("tbl%0d_rv", t), seen_rv, 3'b001);
         check($sformatf("tbl%0d_res", t), seen_res, tbl[t].res);
         check($sformatf("tbl%0d_err", t), seen_err, tbl[t].err);
      end

      // Illegal code on requester 1, then a legal op must clear the error flag.
      issue(1, 3'd6, 32'd1, 32'd0);
      check("ill_rv", seen_rv, 3'b010);
      check("ill_err", seen_err, 1'b1);
      check("ill_res", seen_res, 1'b0);
      issue(1, CMP_GEZ, 32'd4, 32'd0);
      check("legal_err", seen_err, 1'b0);
      check("legal_res", seen_res, 1'b1);

      // Two requesters valid every cycle from ptr=0: strict alternation.
      do_reset();
      set_req(0, 1'b1, CMP_EQ, 32'd1, 32'd1);
      set_req(1, 1'b1, CMP_NEQ, 32'd1, 32'd1);
      for (int t = 0; t < 4; t++) begin
         cycle();
         check($sformatf("alt_grant%0d", t), seen_ready, grant_exp[t]);
      end
      req_valid = '0;
      cycle();
      check("alt_resp_a", seen_rv, 3'b001);
      cycle();
      check("alt_resp_b", seen_rv, 3'b010);
      check("alt_resp_b_res", seen_res, 1'b0);

      // Back-to-back accepts on requester 0 give consecutive responses with no bubble.
      set_req(0, 1'b1, CMP_NEQ, 32'd3, 32'd4);
      cycle();
      set_req(0, 1'b1, CMP_GEZ, 32'hFFFF_FFF9, 32'd0);
      cycle();
      req_valid = '0;
      cycle();
      check("b2b_rv0", seen_rv, 3'b001);
      check("b2b_res0", seen_res, 1'b1);
      cycle();
      check("b2b_rv1", seen_rv, 3'b001);
      check("b2b_res1", seen_res, 1'b0);

      // Reset with both stages full: outputs drop at once, nothing stale afterwards.
      set_req(0, 1'b1, CMP_EQ, 32'd2, 32'd2);
      set_req(2, 1'b1, CMP_EQ, 32'd2, 32'd2);
      cycle();
      cycle();
      check("full_busy", busy, 1'b1);
      do_reset();
      for (int t = 0; t < 3; t++) cycle();
      set_req(2, 1'b1, CMP_LTZ, 32'hFFFF_FFFE, 32'd0);
      cycle();
      check("post_rst_grant", seen_ready, 3'b100);
      req_valid = '0;
      cycle();
      cycle();

      // Random traffic: requesters hold until accepted, sometimes withdraw.
      for (int i = 0; i < N; i++) pending[i] = 0;
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pending[i] && $urandom_range(0, 1) == 1) begin
               ra = rnd_val();
               set_req(i, 1'b1, 3'($urandom_range(0, 7)), ra,
                       ($urandom_range(0, 1) == 1) ? ra : rnd_val());
               pending[i] = 1;
            end else if (pending[i] && $urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
               pending[i] = 0;
            end
         end
         cycle();
         if (last_win >= 0) begin
            pending[last_win] = 0;
            if ($urandom_range(0, 2) != 0) req_valid[last_win] = 1'b0;
            else begin
               ra = rnd_val();
               set_req(last_win, 1'b1, 3'($urandom_range(0, 7)), ra, rnd_val());
               pending[last_win] = 1;
            end
         end
      end
      req_valid = '0;
      repeat (3) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
